imem_loader: RTL and testbench

Boot-time writer for the byte-addressed, big-endian instruction memory.
- Accepts 32-bit instruction words over a valid/ready stream.
- Splits each word into four bytes, MSB first, and writes one byte per cycle through a single-byte write port.
- Holds the core in reset until the last word is written, then releases it.
- Sits between the host or boot source and the instruction memory write port.

---
 rtl/imem_loader.sv | 120 ++++++++++++
 tb/tb_imem_loader.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// imem_loader: boot-time loader that streams 32-bit instruction words into a
// byte-wide, big-endian instruction memory and holds the core in reset until
// the final word of the image has been written.
module imem_loader #(
    parameter int unsigned DEPTH_BYTES = 32,
    parameter int unsigned ADDR_W      = 5,
    parameter int unsigned BASE_ADDR   = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_word,
    input  logic              in_last,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic [ADDR_W-2:0] word_count,
    output logic              load_done,
    output logic              core_hold,
    output logic              overflow_err
);

    // Pointer carries two spare bits so wr_ptr + 4 never wraps at the top of memory.
    localparam int unsigned PTR_W = ADDR_W + 2;
    localparam int unsigned WC_W  = ADDR_W - 1;

    localparam logic [PTR_W-1:0] BASE_PTR   = PTR_W'(BASE_ADDR);
    localparam logic [PTR_W-1:0] END_PTR    = PTR_W'(BASE_ADDR + DEPTH_BYTES);
    localparam logic [PTR_W-1:0] WORD_BYTES = PTR_W'(4);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DONE  = 2'd2,
        ERROR = 2'd3
    } state_t;

    state_t            state;
    logic [PTR_W-1:0]  wr_ptr;
    logic [1:0]        byte_idx;
    logic [31:0]       word_q;
    logic              last_q;
    logic              fits;

    // A new word fits only if all four of its bytes lie inside memory.
    assign fits = (wr_ptr + WORD_BYTES) <= END_PTR;

    // The captured word shifts left one byte per write, so its top byte is always the next byte.
    assign mem_wdata = word_q[31:24];

    // Loader FSM with all control outputs registered alongside the state.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= IDLE;
            wr_ptr       <= BASE_PTR;
            byte_idx     <= 2'd0;
            word_q       <= '0;
            last_q       <= 1'b0;
            word_count   <= '0;
            in_ready     <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= ADDR_W'(BASE_ADDR);
            load_done    <= 1'b0;
            core_hold    <= 1'b1;
            overflow_err <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    in_ready <= 1'b1;
                    if (in_valid && in_ready) begin
                        in_ready <= 1'b0;
                        if (fits) begin
                            word_q   <= in_word;
                            last_q   <= in_last;
                            byte_idx <= 2'd0;
                            mem_we   <= 1'b1;
                            mem_addr <= ADDR_W'(wr_ptr);
                            state    <= WRITE;
                        end else begin
                            overflow_err <= 1'b1;
                            state        <= ERROR;
                        end
                    end
                end

                WRITE: begin
                    if (byte_idx == 2'd3) begin
                        mem_we     <= 1'b0;
                        wr_ptr     <= wr_ptr + WORD_BYTES;
                        word_count <= word_count + WC_W'(1);
                        if (last_q) begin
                            load_done <= 1'b1;
                            core_hold <= 1'b0;
                            state     <= DONE;
                        end else begin
                            in_ready <= 1'b1;
                            state    <= IDLE;
                        end
                    end else begin
                        byte_idx <= byte_idx + 2'd1;
                        mem_addr <= mem_addr + ADDR_W'(1);
                        word_q   <= {word_q[23:0], 8'h00};
                    end
                end

                // Terminal states: only reset leaves them.
                DONE, ERROR: begin
                    in_ready <= 1'b0;
                    mem_we   <= 1'b0;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: randomized bench for imem_loader, checked against a
// word-level model of the load image (pointer, word count, expected bytes).
module tb_imem_loader;

    localparam int unsigned DEPTH  = 32;
    localparam int unsigned ADDR_W = 5;

    logic              clk;
    logic              reset;
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       in_word;
    logic              in_last;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic [ADDR_W-2:0] word_count;
    logic              load_done;
    logic              core_hold;
    logic              overflow_err;

    imem_loader #(
        .DEPTH_BYTES(DEPTH),
        .ADDR_W     (ADDR_W),
        .BASE_ADDR  (0)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_word     (in_word),
        .in_last     (in_last),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .word_count  (word_count),
        .load_done   (load_done),
        .core_hold   (core_hold),
        .overflow_err(overflow_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Model of the load: next word address, words written, and the expected memory image.
    int         model_ptr;
    int         model_cnt;
    logic [7:0] exp_mem [DEPTH];
    logic [7:0] obs_mem [DEPTH];

    // Behavioural memory attached to the write port.
    always @(negedge clk) begin
        if (mem_we === 1'b1) obs_mem[mem_addr] = mem_wdata;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_reset(input int cycles);
        reset    = 1'b0;
        in_valid = 1'b0;
        repeat (cycles) begin
            @(negedge clk);
            check("rst_ready", in_ready, 0);
            check("rst_we", mem_we, 0);
        end
        reset = 1'b1;
        @(negedge clk);
        model_ptr = 0;
        model_cnt = 0;
        check("post_rst_ready", in_ready, 1);
        check("post_rst_hold", core_hold, 1);
        check("post_rst_we", mem_we, 0);
        check("post_rst_done", load_done, 0);
        check("post_rst_ovf", overflow_err, 0);
        check("post_rst_count", word_count, 0);
    endtask

    task automatic wait_ready();
        int n = 0;
        while (in_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("ready_wait", in_ready, 1);
    endtask

    // Offer one word after 'gap' idle cycles and check the resulting writes or overflow.
    task automatic send(input logic [31:0] w, input logic last, input int gap);
        logic [7:0] b;
        for (int g = 0; g < gap; g++) begin
            in_valid = 1'b0;
            in_word  = $urandom;
            in_last  = 1'($urandom);
            @(negedge clk);
            check("gap_we", mem_we, 0);
        end
        wait_ready();
        in_valid = 1'b1;
        in_word  = w;
        in_last  = last;
        @(negedge clk);
        in_valid = 1'b0;
        in_word  = $urandom;
        if (model_ptr + 4 <= int'(DEPTH)) begin
            for (int k = 0; k < 4; k++) begin
                if (k > 0) @(negedge clk);
                b = 8'(w >> (24 - 8 * k));
                check("wr_we", mem_we, 1);
                check("wr_addr", mem_addr, model_ptr + k);
                check("wr_data", mem_wdata, b);
                check("wr_ready", in_ready, 0);
                exp_mem[model_ptr + k] = b;
            end
            model_ptr += 4;
            model_cnt++;
            @(negedge clk);
            check("end_we", mem_we, 0);
            check("end_ready", in_ready, !last);
            check("end_done", load_done, last);
            check("end_hold", core_hold, !last);
            check("end_count", word_count, model_cnt);
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (k > 0) @(negedge clk);
                check("ovf_we", mem_we, 0);
                check("ovf_err", overflow_err, 1);
                check("ovf_ready", in_ready, 0);
                check("ovf_hold", core_hold, 1);
                check("ovf_done", load_done, 0);
            end
        end
    endtask

    // Present valid words in a terminal state; nothing may be accepted or written.
    task automatic valid_ignored(input int n, input logic done, input logic err);
        in_valid = 1'b1;
        repeat (n) begin
            in_word = $urandom;
            @(negedge clk);
            check("term_ready", in_ready, 0);
            check("term_we", mem_we, 0);
            check("term_done", load_done, done);
            check("term_err", overflow_err, err);
            check("term_hold", core_hold, !done);
            check("term_count", word_count, model_cnt);
        end
        in_valid = 1'b0;
    endtask

    // Start a word, let two bytes land, then pull reset during the second byte.
    task automatic send_abort(input logic [31:0] w);
        wait_ready();
        in_valid = 1'b1;
        in_word  = w;
        in_last  = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        check("ab_we0", mem_we, 1);
        check("ab_addr0", mem_addr, model_ptr);
        check("ab_data0", mem_wdata, w[31:24]);
        exp_mem[model_ptr] = w[31:24];
        @(negedge clk);
        check("ab_we1", mem_we, 1);
        check("ab_addr1", mem_addr, model_ptr + 1);
        check("ab_data1", mem_wdata, w[23:16]);
        exp_mem[model_ptr + 1] = w[23:16];
        do_reset(2);
    endtask

    task automatic check_image();
        for (int i = 0; i < int'(DEPTH); i++) check("mem_image", obs_mem[i], exp_mem[i]);
    endtask

    initial begin
        int n;
        for (int i = 0; i < int'(DEPTH); i++) begin
            exp_mem[i] = 8'h00;
            obs_mem[i] = 8'h00;
        end
        reset     = 1'b0;
        in_valid  = 1'b0;
        in_word   = '0;
        in_last   = 1'b0;
        model_ptr = 0;
        model_cnt = 0;

        // Directed image with stalls between words.
        do_reset(2);
        send(32'h8C41000A, 1'b0, 0);
        send(32'hAC610005, 1'b0, 0);
        send(32'h00A31025, 1'b0, 1);
        send(32'h00C70825, 1'b0, 2);
        send(32'h3061000A, 1'b1, 3);
        valid_ignored(3, 1'b1, 1'b0);
        check_image();

        // Exact fill, then one word too many.
        do_reset(2);
        for (int i = 0; i < 8; i++) send($urandom, 1'b0, $urandom_range(0, 3));
        send($urandom, 1'($urandom), 0);
        valid_ignored(3, 1'b0, 1'b1);
        check_image();

        // Exact fill with last on the final word ends in DONE.
        do_reset(2);
        for (int i = 0; i < 8; i++) send($urandom, i == 7, $urandom_range(0, 2));
        valid_ignored(2, 1'b1, 1'b0);

        // Reset during the second byte of the second word, then reload from address 0.
        do_reset(2);
        send($urandom, 1'b0, 0);
        send_abort($urandom);
        send($urandom, 1'b1, 1);
        check_image();

        // Random image lengths.
        for (int r = 0; r < 4; r++) begin
            do_reset($urandom_range(1, 3));
            n = $urandom_range(1, 8);
            for (int i = 0; i < n; i++) send($urandom, i == n - 1, $urandom_range(0, 3));
            valid_ignored(2, 1'b1, 1'b0);
            check_image();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
